mem_load_unit: RTL

MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

---
 rtl/mem_load_unit_pkg.sv | 29 ++
 rtl/mem_load_unit_if.sv | 29 ++
 rtl/mem_load_unit_load_extend.sv | 22 ++
 rtl/mem_load_unit.sv | 68 ++++++
 4 files changed

// File: rtl/mem_load_unit_pkg.sv
// mem_load_unit_pkg: load/store funct3 codes, memory regions and IO address map.
package mem_load_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [31:0] IO_UART_CTRL = 32'h8000_0000;
    localparam logic [31:0] IO_UART_RX   = 32'h8000_0004;
    localparam logic [31:0] IO_CYCLE_CNT = 32'h8000_0010;
    localparam logic [31:0] IO_INSTR_CNT = 32'h8000_0014;
    localparam logic [31:0] IO_CNT_CLR   = 32'h8000_0018;

    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_DMEM = 2'd1,
        RGN_BIOS = 2'd2,
        RGN_IO   = 2'd3
    } region_t;

    function automatic region_t decode_region(input logic [31:0] addr);
        return (addr[31:28] == 4'h1 || addr[31:28] == 4'h3) ? RGN_DMEM :
               (addr[31:28] == 4'h4) ? RGN_BIOS :
               (addr[31:28] == 4'h8) ? RGN_IO : RGN_NONE;
    endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// mem_load_unit_if: memory-stage load bus between the pipeline and the load unit.
interface mem_load_unit_if;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        stall;
    logic        inst_retire;
    logic [31:0] dmem_dout;
    logic [31:0] bios_dout;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic        uart_tx_ready;
    logic [31:0] load_data;
    logic        load_valid;

    modport master (
        output addr, funct3, is_load, is_store, stall, inst_retire,
        output dmem_dout, bios_dout, uart_rx_data, uart_rx_valid, uart_tx_ready,
        input  uart_rx_ready, load_data, load_valid
    );

    modport slave (
        input  addr, funct3, is_load, is_store, stall, inst_retire,
        input  dmem_dout, bios_dout, uart_rx_data, uart_rx_valid, uart_tx_ready,
        output uart_rx_ready, load_data, load_valid
    );
endinterface

// File: rtl/mem_load_unit_load_extend.sv
// load_extend: selects the addressed byte/halfword of a word and sign/zero extends it.
module load_extend
    import mem_load_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = offset[1] ? (offset[0] ? word[31:24] : word[23:16])
                      : (offset[0] ? word[15:8]  : word[7:0]);
        h = offset[1] ? word[31:16] : word[15:0];
        result = (funct3 == F3_LB)  ? {{24{b[7]}}, b} :
                 (funct3 == F3_LBU) ? {24'b0, b} :
                 (funct3 == F3_LH)  ? {{16{h[15]}}, h} :
                 (funct3 == F3_LHU) ? {16'b0, h} : word;
    end
endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: one-cycle load path over DMEM, BIOS and memory-mapped IO,
// with cycle/retired-instruction counters and a UART receive pop.
module mem_load_unit
    import mem_load_unit_pkg::*;
(
    input logic clk,
    input logic rst,
    mem_load_unit_if.slave bus
);
    logic        valid_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    region_t     region_q;
    logic [31:0] io_q;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] io_word;
    logic [31:0] word;
    logic [31:0] result;
    logic        accept;
    logic        clr;

    always_comb begin
        accept = bus.is_load & ~bus.stall;
        clr = bus.is_store & ~bus.stall & (bus.addr == IO_CNT_CLR);
        io_word = (bus.addr == IO_UART_CTRL) ? {30'b0, bus.uart_rx_valid, bus.uart_tx_ready} :
                  (bus.addr == IO_UART_RX)   ? (bus.uart_rx_valid ? {24'b0, bus.uart_rx_data} : 32'b0) :
                  (bus.addr == IO_CYCLE_CNT) ? cycle_cnt :
                  (bus.addr == IO_INSTR_CNT) ? instr_cnt : 32'b0;
        word = (region_q == RGN_DMEM) ? bus.dmem_dout :
               (region_q == RGN_BIOS) ? bus.bios_dout :
               (region_q == RGN_IO)   ? io_q : 32'b0;
    end

    assign bus.uart_rx_ready = ~rst & accept & (bus.addr == IO_UART_RX) & bus.uart_rx_valid;
    assign bus.load_valid = valid_q;
    assign bus.load_data = result;

    load_extend u_ext (
        .word   (word),
        .funct3 (f3_q),
        .offset (off_q),
        .result (result)
    );

    // Counters run regardless of stall; IO word is snapshotted at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            f3_q      <= 3'b0;
            off_q     <= 2'b0;
            region_q  <= RGN_NONE;
            io_q      <= 32'b0;
            cycle_cnt <= 32'b0;
            instr_cnt <= 32'b0;
        end else begin
            cycle_cnt <= clr ? 32'b0 : cycle_cnt + 32'd1;
            instr_cnt <= clr ? 32'b0 : instr_cnt + {31'b0, bus.inst_retire};
            if (!bus.stall) begin
                valid_q  <= bus.is_load;
                f3_q     <= bus.funct3;
                off_q    <= bus.addr[1:0];
                region_q <= bus.is_load ? decode_region(bus.addr) : RGN_NONE;
                io_q     <= io_word;
            end
        end
    end
endmodule
